// File: rtl/trap_ctrl.sv
// Trap sequencer: picks one trap per commit boundary, drains/flushes the pipe, issues the CSR trap command.
// Optional trap/interrupt counters are enabled with `define TRAP_CTRL_CNT_EN.
module trap_ctrl #(
    parameter int XLEN          = 32,
    parameter int DRAIN_TIMEOUT = 15
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    input  logic [XLEN-1:0] i_pc,
    input  logic [31:0]     i_inst,
    input  logic [XLEN-1:0] i_badaddr,
    input  logic            i_ex_inst_addr,
    input  logic            i_ex_illegal,
    input  logic            i_ebreak,
    input  logic            i_ecall,
    input  logic            i_ex_st_addr,
    input  logic            i_ex_ld_addr,
    input  logic            i_mret,
    input  logic            i_irq_msip,
    input  logic            i_irq_mtip,
    input  logic            i_irq_meip,
    input  logic            i_mstatus_mie,
    input  logic            i_mie_msie,
    input  logic            i_mie_mtie,
    input  logic            i_mie_meie,
    input  logic            i_pipe_empty,
    input  logic            i_redirect_ack,
    output logic            o_stall,
    output logic            o_flush,
    output logic            o_trap,
    output logic [XLEN-1:0] o_cause,
    output logic [XLEN-1:0] o_tval,
    output logic [XLEN-1:0] o_epc,
    output logic [XLEN-1:0] o_mip,
    output logic            o_busy,
    output logic            o_drain_err
`ifdef TRAP_CTRL_CNT_EN
    ,
    output logic [XLEN-1:0] o_trap_cnt,
    output logic [XLEN-1:0] o_irq_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, DRAIN, TAKE, WAIT_ACK} state_t;

    localparam int CW = 8;
    localparam logic [XLEN-1:0] IRQ_BIT = XLEN'(1) << (XLEN - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] cause_q, cause_d, tval_q, tval_d, epc_q, epc_d, mip_q, mip_d;
    logic            flush_q, flush_d, trap_q, trap_d, busy_q, busy_d, err_q, err_d;

    logic            ex_any, irq_take;
    logic [XLEN-1:0] sel_cause, sel_tval;

    assign ex_any   = i_ex_inst_addr | i_ex_illegal | i_ebreak | i_ecall | i_ex_st_addr | i_ex_ld_addr;
    assign irq_take = !i_mret && i_mstatus_mie &&
                      ((i_irq_msip & i_mie_msie) | (i_irq_mtip & i_mie_mtie) | (i_irq_meip & i_mie_meie));

    // Exceptions always beat interrupts; within each group the order below is the priority.
    always_comb begin
        sel_cause = '0;
        sel_tval  = '0;
        if (i_ex_inst_addr) begin
            sel_cause = XLEN'(0);
            sel_tval  = i_badaddr;
        end else if (i_ex_illegal) begin
            sel_cause = XLEN'(2);
            sel_tval  = XLEN'(i_inst);
        end else if (i_ebreak) begin
            sel_cause = XLEN'(3);
            sel_tval  = i_pc;
        end else if (i_ecall) begin
            sel_cause = XLEN'(11);
        end else if (i_ex_st_addr) begin
            sel_cause = XLEN'(6);
            sel_tval  = i_badaddr;
        end else if (i_ex_ld_addr) begin
            sel_cause = XLEN'(4);
            sel_tval  = i_badaddr;
        end else if (i_irq_meip && i_mie_meie) begin
            sel_cause = IRQ_BIT | XLEN'(11);
        end else if (i_irq_msip && i_mie_msie) begin
            sel_cause = IRQ_BIT | XLEN'(3);
        end else begin
            sel_cause = IRQ_BIT | XLEN'(7);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        tval_d  = tval_q;
        epc_d   = epc_q;
        err_d   = err_q;
        flush_d = 1'b0;
        trap_d  = 1'b0;
        mip_d   = '0;
        mip_d[3]  = i_irq_msip;
        mip_d[7]  = i_irq_mtip;
        mip_d[11] = i_irq_meip;
        case (state_q)
            IDLE: begin
                if (i_valid && (ex_any || irq_take)) begin
                    cause_d = sel_cause;
                    tval_d  = sel_tval;
                    epc_d   = i_pc;
                    flush_d = 1'b1;
                    cnt_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (i_pipe_empty) begin
                    trap_d  = 1'b1;
                    state_d = TAKE;
                end else if (cnt_q == CW'(DRAIN_TIMEOUT)) begin
                    trap_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = TAKE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            TAKE: state_d = WAIT_ACK;
            WAIT_ACK: begin
                if (i_redirect_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cause_q <= '0;
            tval_q  <= '0;
            epc_q   <= '0;
            mip_q   <= '0;
            flush_q <= 1'b0;
            trap_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
            tval_q  <= tval_d;
            epc_q   <= epc_d;
            mip_q   <= mip_d;
            flush_q <= flush_d;
            trap_q  <= trap_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign o_stall     = busy_q;
    assign o_busy      = busy_q;
    assign o_flush     = flush_q;
    assign o_trap      = trap_q;
    assign o_cause     = cause_q;
    assign o_tval      = tval_q;
    assign o_epc       = epc_q;
    assign o_mip       = mip_q;
    assign o_drain_err = err_q;

`ifdef TRAP_CTRL_CNT_EN
    logic [XLEN-1:0] trap_cnt_q, trap_cnt_d, irq_cnt_q, irq_cnt_d;

    // Counts are bumped at the end of each trap pulse.
    always_comb begin
        trap_cnt_d = trap_cnt_q + XLEN'(trap_q);
        irq_cnt_d  = irq_cnt_q + XLEN'(trap_q & cause_q[XLEN-1]);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            trap_cnt_q <= '0;
            irq_cnt_q  <= '0;
        end else begin
            trap_cnt_q <= trap_cnt_d;
            irq_cnt_q  <= irq_cnt_d;
        end
    end

    assign o_trap_cnt = trap_cnt_q;
    assign o_irq_cnt  = irq_cnt_q;
`endif

endmodule

// File: tb/tb_trap_ctrl.sv
// Randomized self-checking bench for trap_ctrl against a transaction-level reference model.
module tb_trap_ctrl;

    localparam int XLEN = 32;
    localparam int T    = 15;

    logic        i_clk, i_rst, i_valid;
    logic [31:0] i_pc, i_inst, i_badaddr;
    logic        i_ex_inst_addr, i_ex_illegal, i_ebreak, i_ecall, i_ex_st_addr, i_ex_ld_addr;
    logic        i_mret, i_irq_msip, i_irq_mtip, i_irq_meip;
    logic        i_mstatus_mie, i_mie_msie, i_mie_mtie, i_mie_meie;
    logic        i_pipe_empty, i_redirect_ack;
    logic        o_stall, o_flush, o_trap, o_busy, o_drain_err;
    logic [31:0] o_cause, o_tval, o_epc, o_mip;
`ifdef TRAP_CTRL_CNT_EN
    logic [31:0] o_trap_cnt, o_irq_cnt;
`endif

    int checks = 0;
    int errors = 0;
    bit exp_err = 0;
    int model_traps = 0;
    int model_irqs = 0;

    trap_ctrl #(.XLEN(XLEN), .DRAIN_TIMEOUT(T)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_pc(i_pc), .i_inst(i_inst),
        .i_badaddr(i_badaddr), .i_ex_inst_addr(i_ex_inst_addr), .i_ex_illegal(i_ex_illegal),
        .i_ebreak(i_ebreak), .i_ecall(i_ecall), .i_ex_st_addr(i_ex_st_addr),
        .i_ex_ld_addr(i_ex_ld_addr), .i_mret(i_mret), .i_irq_msip(i_irq_msip),
        .i_irq_mtip(i_irq_mtip), .i_irq_meip(i_irq_meip), .i_mstatus_mie(i_mstatus_mie),
        .i_mie_msie(i_mie_msie), .i_mie_mtie(i_mie_mtie), .i_mie_meie(i_mie_meie),
        .i_pipe_empty(i_pipe_empty), .i_redirect_ack(i_redirect_ack), .o_stall(o_stall),
        .o_flush(o_flush), .o_trap(o_trap), .o_cause(o_cause), .o_tval(o_tval), .o_epc(o_epc),
        .o_mip(o_mip), .o_busy(o_busy), .o_drain_err(o_drain_err)
`ifdef TRAP_CTRL_CNT_EN
        , .o_trap_cnt(o_trap_cnt), .o_irq_cnt(o_irq_cnt)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // One clock; mip must show the lines present before the edge.
    task automatic tick;
        logic [31:0] m;
        bit          rst_before;
        m = 32'h0;
        m[3]  = i_irq_msip;
        m[7]  = i_irq_mtip;
        m[11] = i_irq_meip;
        rst_before = i_rst;
        @(posedge i_clk);
        #1;
        checkOutput("mip", o_mip, rst_before ? m : 32'h0);
    endtask

    // Reference decision: which trap (if any) the boundary on the inputs should raise.
    function automatic void model_trap(output bit take, output logic [31:0] cause, output logic [31:0] tval);
        int          codes[6];
        logic [31:0] tv[6];
        bit   [5:0]  fl;
        codes = '{0, 2, 3, 11, 6, 4};
        tv    = '{i_badaddr, i_inst, i_pc, 32'h0, i_badaddr, i_badaddr};
        fl    = {i_ex_ld_addr, i_ex_st_addr, i_ecall, i_ebreak, i_ex_illegal, i_ex_inst_addr};
        take = 0;
        cause = 32'h0;
        tval = 32'h0;
        if (!i_valid) return;
        for (int k = 0; k < 6; k++) begin
            if (fl[k]) begin
                take = 1;
                cause = codes[k];
                tval = tv[k];
                return;
            end
        end
        if (!i_mret && i_mstatus_mie) begin
            if (i_irq_meip && i_mie_meie) begin take = 1; cause = 32'h8000_000B; end
            else if (i_irq_msip && i_mie_msie) begin take = 1; cause = 32'h8000_0003; end
            else if (i_irq_mtip && i_mie_mtie) begin take = 1; cause = 32'h8000_0007; end
        end
    endfunction

    task automatic clearBoundary;
        i_valid = 0;
        {i_ex_ld_addr, i_ex_st_addr, i_ecall, i_ebreak, i_ex_illegal, i_ex_inst_addr} = 6'b0;
        i_mret = 0;
    endtask

    // irq/en are {meip, mtip, msip}; flags are {ld, st, ecall, ebreak, illegal, inst_addr}.
    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] bad,
                                 input logic [5:0] flags, input logic mret, input logic [2:0] irq,
                                 input logic [2:0] en, input logic mie, input int empty_at, input int ack_wait);
        bit          take;
        logic [31:0] c, tv;
        int          k_take;
        i_pc = pc; i_inst = inst; i_badaddr = bad;
        {i_ex_ld_addr, i_ex_st_addr, i_ecall, i_ebreak, i_ex_illegal, i_ex_inst_addr} = flags;
        i_mret = mret;
        {i_irq_meip, i_irq_mtip, i_irq_msip} = irq;
        {i_mie_meie, i_mie_mtie, i_mie_msie} = en;
        i_mstatus_mie = mie;
        i_valid = 1;
        i_pipe_empty = 0;
        i_redirect_ack = 0;
        model_trap(take, c, tv);
        tick;
        clearBoundary();
        i_pc = $urandom; i_inst = $urandom; i_badaddr = $urandom;
        {i_irq_meip, i_irq_mtip, i_irq_msip} = 3'($urandom);
        checkOutput("flush", o_flush, 32'(take));
        checkOutput("busy_accept", o_busy, 32'(take));
        checkOutput("trap_accept", o_trap, 0);
        if (!take) return;
        k_take = (empty_at < T + 1) ? empty_at : T + 1;
        if (empty_at > T + 1) exp_err = 1;
        for (int k = 1; k <= k_take; k++) begin
            i_pipe_empty = (k >= empty_at);
            i_redirect_ack = 1'($urandom);
            i_valid = 1'($urandom);
            i_ex_illegal = 1'($urandom);
            tick;
            checkOutput("stall_drain", o_stall, 1);
            checkOutput("flush_once", o_flush, 0);
            checkOutput("trap_time", o_trap, 32'(k == k_take));
        end
        checkOutput("cause", o_cause, c);
        checkOutput("tval", o_tval, tv);
        checkOutput("epc", o_epc, pc);
        checkOutput("drain_err", o_drain_err, 32'(exp_err));
        i_pipe_empty = 1'($urandom);
        i_redirect_ack = 1'($urandom);
        tick;
        checkOutput("trap_single", o_trap, 0);
        checkOutput("stall_take", o_stall, 1);
        for (int w = 0; w < ack_wait; w++) begin
            i_redirect_ack = 0;
            tick;
            checkOutput("stall_wait", o_stall, 1);
            checkOutput("trap_wait", o_trap, 0);
        end
        clearBoundary();
        i_redirect_ack = 1;
        tick;
        i_redirect_ack = 0;
        model_traps++;
        if (c[31]) model_irqs++;
        checkOutput("stall_release", o_stall, 0);
        checkOutput("busy_release", o_busy, 0);
        checkOutput("cause_hold", o_cause, c);
`ifdef TRAP_CTRL_CNT_EN
        checkOutput("trap_cnt", o_trap_cnt, 32'(model_traps));
        checkOutput("irq_cnt", o_irq_cnt, 32'(model_irqs));
`endif
    endtask

    initial begin
        i_rst = 0;
        i_pc = 0; i_inst = 0; i_badaddr = 0;
        clearBoundary();
        {i_irq_meip, i_irq_mtip, i_irq_msip} = 3'b0;
        {i_mie_meie, i_mie_mtie, i_mie_msie} = 3'b0;
        i_mstatus_mie = 0; i_pipe_empty = 0; i_redirect_ack = 0;
        tick;
        checkOutput("rst_busy", o_busy, 0);
        checkOutput("rst_trap", o_trap, 0);
        checkOutput("rst_cause", o_cause, 0);
        checkOutput("rst_err", o_drain_err, 0);
        i_rst = 1;
        tick;

        applyStimulus(32'h100, 32'hFFFF_FFFF, 32'h0, 6'b000010, 0, 3'b000, 3'b000, 0, 3, 1);
        applyStimulus(32'h200, 32'h13, 32'h203, 6'b100001, 0, 3'b000, 3'b000, 0, 1, 0);
        applyStimulus(32'h300, 32'h13, 32'h0, 6'b000000, 0, 3'b110, 3'b111, 1, 2, 2);
        applyStimulus(32'h304, 32'h13, 32'h0, 6'b000000, 0, 3'b110, 3'b111, 0, 2, 0);
        applyStimulus(32'h400, 32'h13, 32'h0, 6'b000000, 1, 3'b010, 3'b111, 1, 2, 0);
        applyStimulus(32'h404, 32'h13, 32'h0, 6'b000000, 0, 3'b010, 3'b111, 1, 2, 0);
        applyStimulus(32'h500, 32'h13, 32'h0, 6'b001000, 0, 3'b000, 3'b000, 0, 40, 0);
        applyStimulus(32'h600, 32'h13, 32'h0, 6'b000100, 1, 3'b111, 3'b111, 1, 1, 0);

        // Abort mid-drain: everything clears at once and no trap follows.
        applyStimulus(32'h700, 32'h13, 32'h0, 6'b001000, 0, 3'b000, 3'b000, 0, 99, 0);
        i_valid = 1; i_ecall = 1; i_pc = 32'h800; i_pipe_empty = 0;
        tick;
        clearBoundary();
        checkOutput("flush_pre_rst", o_flush, 1);
        tick;
        tick;
        #2 i_rst = 0;
        #1;
        exp_err = 0; model_traps = 0; model_irqs = 0;
        checkOutput("abort_busy", o_busy, 0);
        checkOutput("abort_stall", o_stall, 0);
        checkOutput("abort_cause", o_cause, 0);
        checkOutput("abort_epc", o_epc, 0);
        checkOutput("abort_mip", o_mip, 0);
        checkOutput("abort_err", o_drain_err, 0);
        i_rst = 1;
        i_pipe_empty = 1;
        for (int k = 0; k < 3; k++) begin
            tick;
            checkOutput("abort_no_trap", o_trap, 0);
            checkOutput("abort_idle", o_busy, 0);
        end

        for (int n = 0; n < 3; n++)
            applyStimulus(32'h900 + 32'(n * 4), 32'h73, 32'h0, 6'b001000, 0, 3'b000, 3'b000, 0, 2, 0);
`ifdef TRAP_CTRL_CNT_EN
        checkOutput("trap_cnt_three", o_trap_cnt, 3);
`endif

        for (int n = 0; n < 50; n++) begin
            logic [5:0] fl;
            for (int b = 0; b < 6; b++) fl[b] = ($urandom % 5 == 0);
            applyStimulus($urandom, $urandom, $urandom, fl, ($urandom % 4 == 0), 3'($urandom),
                          3'($urandom), ($urandom % 4 != 0), $urandom_range(1, 20), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Trap sequencer between the pipeline's commit point and the machine-mode CSR file. It collects synchronous exception flags and level-sensitive machine interrupts. It picks one trap per instruction boundary by fixed priority, and drains and flushes the pipeline. It then issues a single-cycle trap command carrying cause, tval and epc to the CSR and holds fetch until the redirect to mtvec is acknowledged.

Parameters:
XLEN, 32, datapath width of cause/tval/epc/pc.
DRAIN_TIMEOUT, 15, maximum DRAIN cycles before forcing TAKE; legal range 1..255.

Ports:
i_clk  in  1  clock, rising edge.
i_rst  in  1  reset; asynchronous, active-low.
i_valid  in  1  instruction at i_pc is at the commit boundary this cycle.
i_pc  in  XLEN  PC of the boundary instruction.
i_inst  in  32  instruction word at the boundary.
i_badaddr  in  XLEN  faulting address for misaligned exceptions.
i_ex_inst_addr, i_ex_illegal, i_ebreak, i_ecall, i_ex_st_addr, i_ex_ld_addr  in  1 each  exception flags, qualified by i_valid.
i_mret  in  1  boundary instruction is MRET.
i_irq_msip, i_irq_mtip, i_irq_meip  in  1 each  level interrupt lines.
i_mstatus_mie  in  1  global interrupt enable from CSR.
i_mie_msie, i_mie_mtie, i_mie_meie  in  1 each  per-source enables from CSR.
i_pipe_empty  in  1  no instruction in flight behind commit.
i_redirect_ack  in  1  fetch has loaded mtvec.
o_stall  out  1  hold fetch/commit.
o_flush  out  1  one-cycle pipeline flush pulse.
o_trap  out  1  one-cycle trap command to CSR.
o_cause  out  XLEN  mcause value; valid with o_trap.
o_tval  out  XLEN  mtval value; valid with o_trap.
o_epc  out  XLEN  mepc value; valid with o_trap.
o_mip  out  XLEN  registered mip view: bit3=msip, bit7=mtip, bit11=meip, others 0.
o_busy  out  1  FSM not in IDLE.
o_drain_err  out  1  sticky; set when DRAIN timed out; cleared only by reset.

Behaviour:
- Reset (async, i_rst=0): FSM=IDLE, drain counter=0. All outputs and captured registers are 0.
- FSM states: IDLE, DRAIN, TAKE, WAIT_ACK. o_busy=1 and o_stall=1 in every state except IDLE.
- IDLE: a trap is accepted only when i_valid=1.
  - Any exception flag set: accept the exception.
  - Otherwise, if i_mret=0 and i_mstatus_mie=1 and (irq AND enable) is nonzero: accept the interrupt.
  - With i_mret=1, interrupts are deferred that cycle; exceptions are still taken.
- Exception priority (high to low) and encoding:
  - inst_addr: cause 0, tval=i_badaddr.
  - illegal: cause 2, tval=zero-extended i_inst.
  - ebreak: cause 3, tval=i_pc.
  - ecall: cause 11, tval 0.
  - st_addr: cause 6, tval=i_badaddr.
  - ld_addr: cause 4, tval=i_badaddr.
- Interrupt priority: MEI (cause 11) > MSI (3) > MTI (7). Interrupt causes have bit XLEN-1 set; tval=0. Exceptions beat interrupts in the same cycle.
- epc=i_pc for every trap; the boundary instruction does not retire.
- On accept: cause/tval/epc are latched. o_flush=1 for that single cycle; go to DRAIN with counter cleared.
- DRAIN: counter increments each cycle.
  - i_pipe_empty=1: go to TAKE next cycle.
  - Counter reaches DRAIN_TIMEOUT first: set o_drain_err and go to TAKE.
- TAKE: o_trap=1 for exactly one cycle with the latched values; go to WAIT_ACK.
- WAIT_ACK: stay until i_redirect_ack=1, then go to IDLE. The next boundary can be accepted on the cycle after returning to IDLE.
- Outside their states, i_pipe_empty and i_redirect_ack are ignored. Exception/irq inputs are ignored outside IDLE.
- Latched values are committed: an interrupt line that drops during DRAIN/WAIT_ACK does not cancel the trap.
- o_cause/o_tval/o_epc hold their latched values until the next accept. Consumers qualify them with o_trap.
- o_mip: registered irq lines, one-cycle latency, independent of the FSM.
- Async reset mid-sequence aborts immediately to IDLE; no o_trap is issued.

Optional Feature:
TRAP_CTRL_CNT_EN.
- Defined: adds output o_trap_cnt [XLEN] and o_irq_cnt [XLEN].
  - o_trap_cnt increments on every o_trap pulse.
  - o_irq_cnt increments only on interrupt traps.
  - Both wrap at 2^XLEN to 0 and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- i_valid=1, i_ex_illegal=1, i_inst=0xFFFFFFFF, i_pc=0x100 -> o_flush next edge; after i_pipe_empty=1, one o_trap with cause=2, tval=0xFFFFFFFF, epc=0x100; o_stall released the cycle after i_redirect_ack.
- i_ex_inst_addr and i_ex_ld_addr together, i_badaddr=0x203 -> cause=0, tval=0x203.
- i_irq_mtip=1 and i_irq_meip=1, all enables=1, i_valid=1 -> cause=0x8000000B; repeat with i_mstatus_mie=0 -> no trap, o_busy stays 0; o_mip=0x880 one cycle after lines rise.
- i_mret=1 with a pending enabled MTI -> no trap that cycle; next i_valid with i_mret=0 -> cause=0x80000007.
- i_pipe_empty held 0 after accept -> o_trap exactly DRAIN_TIMEOUT+1 cycles after accept, o_drain_err=1 and stays 1.
- i_rst asserted during DRAIN -> outputs 0 immediately, no o_trap; with TRAP_CTRL_CNT_EN, o_trap_cnt counts 3 after three completed traps.
